count_capture: RTL and testbench
================================

COUNT_CAPTURE -- requirements
Module: count_capture

Interface
REQ-001 Parameter WIDTH, 8, width of the count value sampled and stored.
REQ-002 Parameter DEPTH_LOG2, 2, log2 of capture FIFO depth (depth = 2^DEPTH_LOG2 = 4).
REQ-003 Parameter EDGE, 0, capture trigger: 0 rising edge of iEvent, 1 falling edge.
REQ-004 iClock  input  1  sole clock; all state on its rising edge.
REQ-005 iReset  input  1  asynchronous, active-low reset.
REQ-006 iCount  input  WIDTH  live count value from the upstream enable counter.
REQ-007 iEvent  input  1  external trigger level.
REQ-008 iRead  input  1  pop request for the FIFO head.
REQ-009 iClear  input  1  synchronous flush of FIFO and overflow flag.
REQ-010 oData  output  WIDTH  FIFO head (first-word-fall-through).
REQ-011 oValid  output  1  FIFO non-empty; oData meaningful.
REQ-012 oFull  output  1  FIFO holds 2^DEPTH_LOG2 entries.
REQ-013 oLevel  output  DEPTH_LOG2+1  current number of stored entries.
REQ-014 oOverflow  output  1  sticky: a capture was dropped.

Function
REQ-015 Trigger edge SHALL be detected by comparing the (optionally synchronized) iEvent level against its registered previous value, per EDGE.
REQ-016 On a detected edge the block SHALL write the iCount value present at that clock edge into the FIFO tail.
REQ-017 FIFO SHALL be circular, read/write pointers DEPTH_LOG2 bits, wrapping from 2^DEPTH_LOG2-1 to 0.
REQ-018 oData SHALL equal the oldest entry whenever oValid=1, with no read latency; value when oValid=0 is don't-care.
REQ-019 iRead=1 with oValid=1 SHALL pop one entry at the clock edge; iRead with oValid=0 SHALL be ignored.
REQ-020 Write and pop in the same cycle SHALL both occur; oLevel unchanged; valid also when full (no overflow) and when level=1.
REQ-021 Write when full without simultaneous pop SHALL be dropped, FIFO contents unchanged, oOverflow set to 1.
REQ-022 oOverflow SHALL remain 1 until iClear or reset; pops do not clear it.
REQ-023 iClear=1 SHALL at the clock edge empty the FIFO (oLevel=0) and clear oOverflow, taking priority over any same-cycle write or pop; edge-detect history still updates.
REQ-024 oFull=1 iff oLevel=2^DEPTH_LOG2; oValid=1 iff oLevel!=0.
REQ-025 iCount SHALL be stored as-is, no arithmetic; count wrap-around upstream is not interpreted.

Reset
REQ-026 iReset low SHALL immediately force oLevel=0, oValid=0, oFull=0, oOverflow=0, pointers 0, synchronizer and edge history to the inactive level for EDGE (0 for rising, 1 for falling).
REQ-027 Reset asserted mid-operation SHALL discard all stored captures; no edge SHALL be detected on the first clock after release unless iEvent changes.
REQ-028 Stored FIFO data RAM need not be reset.

Configuration
REQ-029 Macro COUNT_CAPTURE_SYNC_EN defined: iEvent SHALL pass a two-flop synchronizer; a transition first sampled at edge k is written at edge k+2 with iCount as sampled at edge k+2.
REQ-030 Macro undefined: iEvent is synchronous to iClock; a transition first sampled at edge k is written at edge k with iCount sampled at edge k.

Verification (WIDTH=8, DEPTH_LOG2=2, EDGE=0, macro undefined unless stated)
REQ-031 Reset release, iEvent=0 -> oValid=0, oLevel=0, oOverflow=0; no write.
REQ-032 iCount incrementing, rising iEvent sampled when iCount=8'h10, later at 8'h25 -> oLevel=2, oData=8'h10; iRead one cycle -> oData=8'h25, oLevel=1.
REQ-033 Five rising edges (counts 1,2,3,4,5), no reads -> oFull=1, oLevel=4, oOverflow=1, pops return 1,2,3,4.
REQ-034 Full FIFO, edge at count 8'h7F with iRead=1 same cycle -> oLevel stays 4, oOverflow stays 0, last entry 8'h7F.
REQ-035 FIFO level 3, oOverflow=1, iClear=1 with edge same cycle -> oLevel=0, oOverflow=0, edge not captured.
REQ-036 COUNT_CAPTURE_SYNC_EN defined, iEvent rises before edge where iCount=8'h40, counter +1 per cycle -> captured value 8'h42.

Source files
------------

// File: rtl/count_capture_if.sv
//------------------------------------------------------------------------------
// Module   : count_capture_if
// Purpose  : Groups the count_capture data path into one bundle. This covers
//            the live count, the trigger level, the pop and flush controls,
//            and the FIFO status and head outputs.
// Ports    : iCount    live count value (WIDTH)
//            iEvent    external trigger level
//            iRead     pop request for FIFO head
//            iClear    synchronous flush of FIFO and overflow flag
//            oData     FIFO head, first-word-fall-through (WIDTH)
//            oValid    FIFO non-empty
//            oFull     FIFO holds 2^DEPTH_LOG2 entries
//            oLevel    number of stored entries (DEPTH_LOG2+1)
//            oOverflow sticky: a capture was dropped
// Modports : master - stimulus side, drives the i* signals
//            slave  - count_capture side, drives the o* signals
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface count_capture_if #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 2
);
  logic [WIDTH-1:0]    iCount;
  logic                iEvent;
  logic                iRead;
  logic                iClear;
  logic [WIDTH-1:0]    oData;
  logic                oValid;
  logic                oFull;
  logic [DEPTH_LOG2:0] oLevel;
  logic                oOverflow;

  modport master (
    output iCount, iEvent, iRead, iClear,
    input  oData, oValid, oFull, oLevel, oOverflow
  );

  modport slave (
    input  iCount, iEvent, iRead, iClear,
    output oData, oValid, oFull, oLevel, oOverflow
  );
endinterface

`default_nettype wire

// File: rtl/count_capture.sv
//------------------------------------------------------------------------------
// Module   : count_capture
// Purpose  : Samples a live counter value on a selected edge of an external
//            event. The samples are queued in a small circular FIFO whose head
//            is first-word-fall-through. A sticky flag records any capture that
//            was dropped because the FIFO was full.
// Ports    : iClock  sole clock, rising edge
//            iReset  asynchronous, active-low reset
//            bus     count_capture_if.slave (count, event, read, clear,
//                    data, valid, full, level, overflow)
// Params   : WIDTH      width of the captured count
//            DEPTH_LOG2 log2 of FIFO depth
//            EDGE       0 = capture on rising iEvent, 1 = on falling iEvent
// Config   : COUNT_CAPTURE_SYNC_EN - when defined, iEvent passes a two-flop
//            synchronizer before edge detection (two cycles extra latency)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module count_capture #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 2,
  parameter int EDGE       = 0
) (
  input  wire logic       iClock,
  input  wire logic       iReset,
  count_capture_if.slave  bus
);

  localparam int unsigned         c_DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] c_LEVEL_FULL = (DEPTH_LOG2+1)'(c_DEPTH);
  localparam logic [DEPTH_LOG2:0] c_LEVEL_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE  = DEPTH_LOG2'(1);
  // Level the event history idles at, so reset never looks like an edge.
  localparam logic                c_IDLE_LVL   = (EDGE != 0);

  logic                  w_evt_lvl;
  logic                  r_evt_prev;
  logic                  w_edge;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_push;
  logic                  w_drop;
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic                  r_ovf;
  logic [WIDTH-1:0]      r_mem [c_DEPTH];

  //--------------------------------------------------------------------------
  // Event level source
  //--------------------------------------------------------------------------
`ifdef COUNT_CAPTURE_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      r_sync1 <= c_IDLE_LVL;
      r_sync2 <= c_IDLE_LVL;
    end else begin
      r_sync1 <= bus.iEvent;
      r_sync2 <= r_sync1;
    end
  end

  assign w_evt_lvl = r_sync2;
`else
  // iEvent is already synchronous: the edge is seen at the clock edge where
  // the new level is first sampled, together with that cycle's iCount.
  assign w_evt_lvl = bus.iEvent;
`endif

  // History keeps updating during iClear, so a flush never creates or hides
  // an edge on the following cycle.
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      r_evt_prev <= c_IDLE_LVL;
    end else begin
      r_evt_prev <= w_evt_lvl;
    end
  end

  assign w_edge = (EDGE == 0) ? (w_evt_lvl & ~r_evt_prev)
                              : (~w_evt_lvl & r_evt_prev);

  //--------------------------------------------------------------------------
  // FIFO control
  //--------------------------------------------------------------------------
  assign w_full = (r_level == c_LEVEL_FULL);
  assign w_pop  = bus.iRead & (r_level != '0);
  // A same-cycle pop frees the slot, so a full FIFO still accepts the write.
  assign w_push = w_edge & (~w_full | w_pop);
  assign w_drop = w_edge & w_full & ~w_pop;

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else if (bus.iClear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_PTR_ONE;
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + c_LEVEL_ONE;
      end else if (!w_push && w_pop) begin
        r_level <= r_level - c_LEVEL_ONE;
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Storage carries no reset; the pointers and level define what is valid.
  always_ff @(posedge iClock) begin
    if (w_push && !bus.iClear) begin
      r_mem[r_wptr] <= bus.iCount;
    end
  end

  //--------------------------------------------------------------------------
  // Outputs
  //--------------------------------------------------------------------------
  assign bus.oData     = r_mem[r_rptr];
  assign bus.oValid    = (r_level != '0);
  assign bus.oFull     = w_full;
  assign bus.oLevel    = r_level;
  assign bus.oOverflow = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_count_capture.sv
//------------------------------------------------------------------------------
// Module   : tb_count_capture
// Purpose  : Self-checking bench for count_capture. The bench models the
//            event path and FIFO contents with a queue. Expected captures are
//            pushed when the triggering stimulus is driven, and popped and
//            compared when the DUT presents them at the FIFO head.
// Config   : COUNT_CAPTURE_SYNC_EN - the model adds the two-flop delay
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_count_capture;

  localparam int c_WIDTH      = 8;
  localparam int c_DEPTH_LOG2 = 2;
  localparam int c_DEPTH      = 4;

  logic r_clk;
  logic r_rst_n;

  count_capture_if #(.WIDTH(c_WIDTH), .DEPTH_LOG2(c_DEPTH_LOG2)) bus ();

  count_capture #(
    .WIDTH      (c_WIDTH),
    .DEPTH_LOG2 (c_DEPTH_LOG2),
    .EDGE       (0)
  ) u_dut (
    .iClock (r_clk),
    .iReset (r_rst_n),
    .bus    (bus)
  );

  initial r_clk = 1'b0;
  always #5 r_clk = ~r_clk;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] q_exp [$];
  logic       m_ovf;
  logic       m_prev;
  logic       m_s1;
  logic       m_s2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic status(input string tag);
    chk({tag, ".level"},    32'(bus.oLevel),    32'(q_exp.size()));
    chk({tag, ".valid"},    32'(bus.oValid),    32'(q_exp.size() != 0));
    chk({tag, ".full"},     32'(bus.oFull),     32'(q_exp.size() == c_DEPTH));
    chk({tag, ".overflow"}, 32'(bus.oOverflow), 32'(m_ovf));
  endtask

  task automatic model_reset();
    q_exp.delete();
    m_ovf  = 1'b0;
    m_prev = 1'b0;
    m_s1   = 1'b0;
    m_s2   = 1'b0;
  endtask

  // One clock cycle. This is entered and left 1 time unit after a rising edge.
  task automatic clk1(input logic [7:0] cnt, input logic ev, input logic rd, input logic clr);
    logic       lvl;
    logic       edg;
    logic [7:0] head;
    bus.iCount = cnt;
    bus.iEvent = ev;
    bus.iRead  = rd;
    bus.iClear = clr;
`ifdef COUNT_CAPTURE_SYNC_EN
    lvl  = m_s2;
    m_s2 = m_s1;
    m_s1 = ev;
`else
    lvl = ev;
`endif
    edg    = lvl & ~m_prev;
    m_prev = lvl;
    if (clr) begin
      q_exp.delete();
      m_ovf = 1'b0;
    end else begin
      if (rd && q_exp.size() != 0) begin
        head = q_exp.pop_front();
        chk("pop.data", 32'(bus.oData), 32'(head));
      end
      if (edg) begin
        if (q_exp.size() < c_DEPTH) q_exp.push_back(cnt);
        else m_ovf = 1'b1;
      end
    end
    @(posedge r_clk);
    #1;
  endtask

  task automatic pulse(input logic [7:0] cnt);
    clk1(cnt, 1'b1, 1'b0, 1'b0);
    clk1(cnt + 8'd1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 8; i++) clk1(8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    r_rst_n    = 1'b0;
    bus.iCount = '0;
    bus.iEvent = 1'b0;
    bus.iRead  = 1'b0;
    bus.iClear = 1'b0;
    model_reset();
    repeat (3) @(posedge r_clk);
    #1;
    status("in_reset");
    r_rst_n = 1'b1;
    clk1(8'h00, 1'b0, 1'b0, 1'b0);
    clk1(8'h01, 1'b0, 1'b0, 1'b0);
    status("after_release");

    // Two captures from an incrementing counter, then a single pop.
    for (int c = 8'h0C; c < 8'h2C; c++) begin
      clk1(8'(c), (c == 8'h10) || (c == 8'h25), 1'b0, 1'b0);
    end
    status("two_caps");
    if (q_exp.size() != 0) chk("two_caps.head", 32'(bus.oData), 32'(q_exp[0]));
`ifndef COUNT_CAPTURE_SYNC_EN
    chk("two_caps.head_const", 32'(bus.oData), 32'h10);
`endif
    clk1(8'h2C, 1'b0, 1'b1, 1'b0);
    status("one_pop");
    if (q_exp.size() != 0) chk("one_pop.head", 32'(bus.oData), 32'(q_exp[0]));
    drain();
    status("drained1");

    // Five captures without reads: the fifth is dropped.
    for (int i = 1; i <= 5; i++) pulse(8'(i));
    clk1(8'h00, 1'b0, 1'b0, 1'b0);
    clk1(8'h00, 1'b0, 1'b0, 1'b0);
    status("overfill");
    drain();
    status("overfill_drained");

    // Read while empty is ignored.
    clk1(8'h00, 1'b0, 1'b1, 1'b0);
    status("empty_read");

    // Clear, fill, then capture while popping a full FIFO.
    clk1(8'h00, 1'b0, 1'b0, 1'b1);
    status("cleared");
    for (int i = 0; i < 4; i++) pulse(8'(8'hA0 + i));
    clk1(8'h00, 1'b0, 1'b0, 1'b0);
    clk1(8'h00, 1'b0, 1'b0, 1'b0);
    status("full_again");
    clk1(8'h7F, 1'b1, 1'b1, 1'b0);
    clk1(8'h80, 1'b0, 1'b0, 1'b0);
    clk1(8'h81, 1'b0, 1'b0, 1'b0);
    status("full_push_pop");
`ifndef COUNT_CAPTURE_SYNC_EN
    chk("full_push_pop.tail", 32'(q_exp[3]), 32'h7F);
`endif
    drain();

    // Level 3 with overflow set, then clear with a same-cycle edge.
    clk1(8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) pulse(8'(8'h50 + 2 * i));
    clk1(8'h00, 1'b0, 1'b0, 1'b0);
    clk1(8'h00, 1'b0, 1'b0, 1'b0);
    clk1(8'h00, 1'b0, 1'b1, 1'b0);
    status("lvl3_ovf");
    clk1(8'h99, 1'b1, 1'b0, 1'b1);
    clk1(8'h9A, 1'b0, 1'b0, 1'b0);
`ifndef COUNT_CAPTURE_SYNC_EN
    status("clear_edge");
`endif
    drain();
    clk1(8'h00, 1'b0, 1'b0, 1'b1);
    status("clear_again");

    // Simultaneous push and pop at level 1.
    pulse(8'h31);
    clk1(8'h00, 1'b0, 1'b0, 1'b0);
    clk1(8'h00, 1'b0, 1'b0, 1'b0);
    clk1(8'h33, 1'b1, 1'b1, 1'b0);
    clk1(8'h34, 1'b0, 1'b0, 1'b0);
    clk1(8'h35, 1'b0, 1'b0, 1'b0);
    status("lvl1_push_pop");
    if (q_exp.size() != 0) chk("lvl1.head", 32'(bus.oData), 32'(q_exp[0]));

    // Asynchronous reset mid-operation discards everything.
    pulse(8'h61);
    clk1(8'h00, 1'b0, 1'b0, 1'b0);
    clk1(8'h00, 1'b0, 1'b0, 1'b0);
    r_rst_n = 1'b0;
    #1;
    model_reset();
    status("mid_reset");
    @(posedge r_clk);
    #2;
    r_rst_n = 1'b1;
    #1;
    @(posedge r_clk);
    #1;
    clk1(8'h00, 1'b0, 1'b0, 1'b0);
    status("post_reset");

`ifdef COUNT_CAPTURE_SYNC_EN
    // Synchronized path: a rise first sampled at count 0x40 stores 0x42.
    clk1(8'h3F, 1'b0, 1'b0, 1'b0);
    clk1(8'h40, 1'b1, 1'b0, 1'b0);
    clk1(8'h41, 1'b1, 1'b0, 1'b0);
    clk1(8'h42, 1'b1, 1'b0, 1'b0);
    clk1(8'h43, 1'b0, 1'b0, 1'b0);
    status("sync_cap");
    chk("sync_cap.data", 32'(bus.oData), 32'h42);
    drain();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
